// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer (32-step shift/add, restoring divide)
module muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_kill,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_rs2,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int W = DATA_WIDTH;
    localparam logic [5:0] LAST_STEP = 6'(W - 1);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t       r_state;
    logic [5:0]   r_cnt;
    logic [2:0]   r_op;
    logic         r_neg_q;
    logic         r_neg_r;
    logic [W-1:0] r_opb;
    logic [2*W-1:0] r_acc;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_result;

    logic         w_signed1, w_signed2, w_s1, w_s2;
    logic [W-1:0] w_mag1, w_mag2;
    logic         w_is_div, w_div0, w_ovf, w_special;
    logic [W-1:0] w_special_res;
    logic [W:0]   w_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]   w_shift, w_trial;
    logic         w_q_bit;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0] w_quo_fix, w_rem_fix, w_fix_res;

    assign o_busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_result;

    assign w_signed1 = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU)
                    || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_signed2 = (i_op == OP_MUL) || (i_op == OP_MULH)
                    || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_s1   = w_signed1 & i_rs1[W-1];
    assign w_s2   = w_signed2 & i_rs2[W-1];
    assign w_mag1 = w_s1 ? -i_rs1 : i_rs1;
    assign w_mag2 = w_s2 ? -i_rs2 : i_rs2;

    // Divide-by-zero and signed overflow bypass the loop entirely
    assign w_is_div  = i_op[2];
    assign w_div0    = w_is_div && (i_rs2 == '0);
    assign w_ovf     = ((i_op == OP_DIV) || (i_op == OP_REM))
                    && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
    assign w_special = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (i_op[1] ? i_rs1 : '1)
                                  : (i_op[1] ? '0 : MIN_NEG);

    assign w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};

    assign w_shift = {r_rem, r_acc[W-1]};
    assign w_trial = w_shift - {1'b0, r_opb};
    assign w_q_bit = ~w_trial[W];

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            3'b000:                 w_fix_res = w_prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*W-1:W];
            3'b100, 3'b101:         w_fix_res = w_quo_fix;
            default:                w_fix_res = w_rem_fix;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (i_kill) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_op    <= i_op;
                        r_neg_q <= w_s1 ^ w_s2;
                        r_neg_r <= w_s1;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        if (w_is_div) begin
                            r_opb <= w_mag2;
                            r_acc <= {{W{1'b0}}, w_mag1};
                        end else begin
                            r_opb <= w_mag1;
                            r_acc <= {{W{1'b0}}, w_mag2};
                        end
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_op[2]) begin
                        r_rem <= w_q_bit ? w_trial[W-1:0] : w_shift[W-1:0];
                        r_acc <= {r_acc[2*W-1:W], r_acc[W-2:0], w_q_bit};
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide sequencer for the execute stage, sitting beside the single-cycle ALU. It accepts one M-extension operation per start pulse, computes it over a fixed 32-step shift/add or shift/subtract loop on internally latched operands, and holds the result until the next start. While it runs, the hazard logic stalls the pipeline using `busy`.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Only 32 is supported, and iteration count equals `DATA_WIDTH`.
- `clk`  in  1  sole clock, rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `kill`  in  1  pipeline flush. Aborts any operation in flight.
- `start`  in  1  launch request. Sampled only when `busy`=0.
- `op`  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  in  DATA_WIDTH  dividend / multiplicand.
- `rs2`  in  DATA_WIDTH  divisor / multiplier.
- `busy`  out  1  operation in progress; the pipeline must stall.
- `done`  out  1  one-cycle pulse, `result` valid.
- `result`  out  DATA_WIDTH  final value, held until the next accepted start.

## Operation
- States:
  - IDLE: wait for start.
  - CALC: 32 iterations, driven by a 6-bit step counter.
  - FIX: sign correction and result select.
  - DONE: pulse `done`.
- Transitions:
  - IDLE/DONE -> CALC on an accepted start.
  - IDLE/DONE -> DONE directly on a special-case start (see below).
  - CALC -> FIX when the counter reaches 31.
  - FIX -> DONE.
  - DONE -> IDLE when `start`=0.
- Start acceptance:
  - Accepted when `start`=1, `busy`=0 and `kill`=0.
  - On acceptance, `op`, `rs1` and `rs2` are latched; later changes on these inputs are ignored.
  - `start` while `busy`=1 is ignored. It is not queued.
- Signed handling:
  - Operand magnitudes are latched along with a result-negate flag.
  - MUL/MULH: both operands signed.
  - MULHSU: `rs1` signed, `rs2` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
- Multiply:
  - Unsigned shift-add into a 64-bit product register.
  - FIX applies two's-complement negation of the 64-bit product when the negate flag is set.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Restoring division with a 33-bit partial remainder, on magnitudes.
  - Quotient sign = sign(`rs1`) XOR sign(`rs2`).
  - Remainder sign = sign(`rs1`).
- Special cases are detected at start, skip CALC/FIX, and reach DONE in the next cycle:
  - Divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = latched `rs1`.
  - Signed overflow (DIV, `rs1`=0x80000000, `rs2`=0xFFFFFFFF): result = 0x80000000. The same condition on REM gives result = 0.
- Kill and reset:
  - `kill` in any state forces IDLE at the next edge. `done` is suppressed and `result` is unchanged.
  - `kill` takes priority over `start` in the same cycle.
  - `rst_n`=0 at an edge forces IDLE, with `busy`=0, `done`=0, `result`=0, counter=0, regardless of state.

## Timing
- Reset values: `busy` 0, `done` 0, `result` 0, state IDLE.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- `busy` = 1 exactly in CALC and FIX.
- `done` = 1 exactly in DONE.
- Normal op, with start accepted at edge 0:
  - CALC occupies cycles 1–32.
  - FIX occupies cycle 33.
  - DONE occupies cycle 34.
  - Fixed 34-cycle latency, independent of operand values.
- Special case: DONE in cycle 1; `busy` never asserts.
- `result` is updated at the edge entering DONE and is stable from that cycle until the next DONE.
- Back-to-back: a start in the DONE cycle is accepted, giving the next `done` 34 cycles later. Throughput is one op per 34 cycles.
- Counter wrap: the counter resets to 0 on entering CALC. It never wraps within an operation.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) -> `busy` high cycles 1–33, `done` in cycle 34, `result` 0xFFFFFFEB.
- High multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
- Special cases (each -> `done` in cycle 1, `busy` stays 0):
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Kill and reset mid-operation:
  - `kill` in cycle 10 of a DIVU -> `busy` 0 from cycle 11, no `done`, `result` keeps its prior value.
  - `rst_n`=0 in cycle 20 -> all outputs 0 next cycle.
- Handshake:
  - `start` with different operands in cycle 15 -> ignored; the original result is returned.
  - `start` in the DONE cycle -> accepted, second `done` 34 cycles later.
  - `start`+`kill` together -> not accepted.
